block_dispatcher: RTL

Kernel-launch stage directly downstream of the device control register. It consumes the latched `thread_count` and the host `start` level, splits the kernel into fixed-size thread blocks, and hands blocks to compute cores one at a time per core. It re-issues work to each core as that core reports completion, and raises `done` once every block has finished.

---
 rtl/block_dispatcher.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel into fixed-size thread blocks and
// hands them to compute cores, re-issuing as each core completes.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : host launch level, held for the kernel
//   thread_count[7:0]  : total kernel threads, latched on launch
//   core_done[N]       : per-core completion, honoured while started
//   core_start[N]      : per-core run request
//   core_reset[N]      : per-core reset request
//   core_block_id      : N x 8-bit block index per core
//   core_thread_count  : N x TW-bit active threads per core
//   done               : kernel complete
module block_dispatcher #(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             thread_count,
    input  logic [NUM_CORES-1:0]   core_done,
    output logic [NUM_CORES-1:0]   core_start,
    output logic [NUM_CORES-1:0]   core_reset,
    output logic [NUM_CORES*8-1:0] core_block_id,
    output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0]
                                   core_thread_count,
    output logic                   done
);

    localparam int TW = $clog2(THREADS_PER_BLOCK) + 1;
    localparam logic [8:0] TPB9 = 9'(THREADS_PER_BLOCK);
    localparam logic [7:0] TPB8 = 8'(THREADS_PER_BLOCK);
    localparam logic [TW-1:0] TPB_TW = TW'(THREADS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0] tc_q, tc_d;
    logic [7:0] total_q, total_d;
    logic [7:0] disp_q, disp_d;
    logic [7:0] bdone_q, bdone_d;

    logic [NUM_CORES-1:0]    start_d;
    logic [NUM_CORES-1:0]    rst_d;
    logic [NUM_CORES*8-1:0]  id_d;
    logic [NUM_CORES*TW-1:0] cnt_d;
    logic                    done_d;

    logic [7:0] next_id;
    logic [7:0] done_cnt;
    logic [7:0] rem;

    // Threads in the final partial block (0 when the split is even).
    assign rem = tc_q % TPB8;

    always_comb begin
        state_d  = state_q;
        tc_d     = tc_q;
        total_d  = total_q;
        disp_d   = disp_q;
        bdone_d  = bdone_q;
        start_d  = core_start;
        rst_d    = core_reset;
        id_d     = core_block_id;
        cnt_d    = core_thread_count;
        done_d   = done;
        next_id  = disp_q;
        done_cnt = bdone_q;

        unique case (state_q)
            IDLE: begin
                rst_d   = '1;
                start_d = '0;
                done_d  = 1'b0;
                if (start) begin
                    tc_d    = thread_count;
                    // 9-bit numerator so 255 + TPB - 1 cannot wrap.
                    total_d = 8'(({1'b0, thread_count}
                                  + TPB9 - 9'd1) / TPB9);
                    disp_d  = '0;
                    bdone_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bdone_q == total_q) begin
                    done_d  = 1'b1;
                    rst_d   = '1;
                    start_d = '0;
                    state_d = DONE;
                end else begin
                    // Ids go out in ascending core order; next_id
                    // ripples through the loop.
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (core_reset[i]) begin
                            rst_d[i] = 1'b0;
                            if (next_id < total_q) begin
                                start_d[i]       = 1'b1;
                                id_d[i*8 +: 8]   = next_id;
                                cnt_d[i*TW +: TW] =
                                    (next_id == total_q - 8'd1 &&
                                     rem != 8'd0) ? TW'(rem) : TPB_TW;
                                next_id = next_id + 8'd1;
                            end
                        end else if (core_start[i] && core_done[i]) begin
                            start_d[i] = 1'b0;
                            rst_d[i]   = 1'b1;
                            done_cnt   = done_cnt + 8'd1;
                        end
                    end
                    disp_d  = next_id;
                    bdone_d = done_cnt;
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            tc_q              <= '0;
            total_q           <= '0;
            disp_q            <= '0;
            bdone_q           <= '0;
            core_start        <= '0;
            core_reset        <= '1;
            core_block_id     <= '0;
            core_thread_count <= '0;
            done              <= 1'b0;
        end else begin
            state_q           <= state_d;
            tc_q              <= tc_d;
            total_q           <= total_d;
            disp_q            <= disp_d;
            bdone_q           <= bdone_d;
            core_start        <= start_d;
            core_reset        <= rst_d;
            core_block_id     <= id_d;
            core_thread_count <= cnt_d;
            done              <= done_d;
        end
    end

endmodule
